// File: rtl/register_file_sb_if.sv
// Register file bus: read ports, writeback, issue reservation and status outputs.
// The master side is the pipeline (decode/writeback/hazard logic), the slave side is the file.
interface register_file_sb_if #(
   parameter int unsigned ADDRESS_WIDTH = 5,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned NUM_READ      = 2
);
   logic [NUM_READ*ADDRESS_WIDTH-1:0] RA;
   logic [NUM_READ*DATA_WIDTH-1:0]    RD;
   logic [NUM_READ-1:0]               RDY;
   logic                              WE3;
   logic [ADDRESS_WIDTH-1:0]          AD3;
   logic [DATA_WIDTH-1:0]             WD3;
   logic                              issue_en;
   logic [ADDRESS_WIDTH-1:0]          issue_rd;
   logic                              waw_hazard;
   logic [ADDRESS_WIDTH:0]            busy_count;
   logic [DATA_WIDTH-1:0]             a0;

   modport master (
      output RA, WE3, AD3, WD3, issue_en, issue_rd,
      input  RD, RDY, waw_hazard, busy_count, a0
   );

   modport slave (
      input  RA, WE3, AD3, WD3, issue_en, issue_rd,
      output RD, RDY, waw_hazard, busy_count, a0
   );
endinterface

// File: rtl/register_file_sb.sv
// Pipelined-core register file: combinational reads, one synchronous write port,
// x0 hardwired to zero, optional write-to-read bypass and a per-register busy scoreboard.
module register_file_sb #(
   parameter int unsigned ADDRESS_WIDTH = 5,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned NUM_READ      = 2,
   parameter int unsigned BYPASS        = 1,
   parameter int unsigned A0_INDEX      = 10
) (
   input logic               clk,
   input logic               rst,
   register_file_sb_if.slave bus
);
   localparam int unsigned Depth = 1 << ADDRESS_WIDTH;
   localparam bit Bypass = (BYPASS != 0);
   localparam logic [ADDRESS_WIDTH-1:0] A0Addr = ADDRESS_WIDTH'(A0_INDEX);

   logic [DATA_WIDTH-1:0]  regs_q [Depth];
   logic [Depth-1:0]       busy_q, busy_d;
   logic [ADDRESS_WIDTH:0] busy_count_q, busy_count_d;
   logic                   wr_valid, issue_valid;

   assign wr_valid    = bus.WE3 && (bus.AD3 != '0);
   assign issue_valid = bus.issue_en && (bus.issue_rd != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_valid) begin
         regs_q[bus.AD3] <= bus.WD3;
      end
   end

   // Issue is applied after writeback so a same-register collision leaves the bit set.
   always_comb begin
      busy_d = busy_q;
      if (wr_valid) begin
         busy_d[bus.AD3] = 1'b0;
      end
      if (issue_valid) begin
         busy_d[bus.issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_comb begin
      busy_count_d = '0;
      for (int unsigned i = 0; i < Depth; i++) begin
         busy_count_d = busy_count_d + (ADDRESS_WIDTH + 1)'(busy_d[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q       <= '0;
         busy_count_q <= '0;
      end else begin
         busy_q       <= busy_d;
         busy_count_q <= busy_count_d;
      end
   end

   for (genvar i = 0; i < NUM_READ; i++) begin : g_read
      logic [ADDRESS_WIDTH-1:0] ra;
      logic                     fwd;

      assign ra  = bus.RA[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      assign fwd = Bypass && wr_valid && (bus.AD3 == ra);

      assign bus.RD[i*DATA_WIDTH +: DATA_WIDTH] = (ra == '0) ? '0 :
                                                  fwd        ? bus.WD3 : regs_q[ra];
      assign bus.RDY[i] = (ra == '0) || fwd || !busy_q[ra];
   end

   assign bus.waw_hazard = issue_valid && busy_q[bus.issue_rd];
   assign bus.busy_count = busy_count_q;
   assign bus.a0         = regs_q[A0Addr];
endmodule

// File: tb/tb_register_file_sb.sv
// Randomised and directed bench for register_file_sb; one bypassing and one
// non-bypassing instance share stimulus and are compared against an array model.
module tb_register_file_sb;
   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;
   localparam int unsigned NR = 2;
   localparam int unsigned NREG = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   register_file_sb_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR)) bus ();
   register_file_sb_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR)) bus_nb ();

   register_file_sb #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .BYPASS(1),
                      .A0_INDEX(10)) u_dut (.clk(clk), .rst(rst), .bus(bus));
   register_file_sb #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .BYPASS(0),
                      .A0_INDEX(10)) u_dut_nb (.clk(clk), .rst(rst), .bus(bus_nb));

   assign bus_nb.RA       = bus.RA;
   assign bus_nb.WE3      = bus.WE3;
   assign bus_nb.AD3      = bus.AD3;
   assign bus_nb.WD3      = bus.WD3;
   assign bus_nb.issue_en = bus.issue_en;
   assign bus_nb.issue_rd = bus.issue_rd;

   // Reference state and the stimulus currently applied.
   logic [DW-1:0] mem [NREG];
   bit            busy_m [NREG];
   int unsigned   t_ra [NR];
   bit            t_we, t_ien;
   int unsigned   t_ad, t_ird;
   logic [DW-1:0] t_wd;
   int            checks = 0;
   int            failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) begin
         mem[i]    = '0;
         busy_m[i] = 1'b0;
      end
   endtask

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < NREG; i++) n += int'(busy_m[i]);
      return n;
   endfunction

   task automatic drive(input int unsigned ra0, input int unsigned ra1, input bit we,
                        input int unsigned ad, input logic [DW-1:0] wd, input bit ien,
                        input int unsigned ird);
      t_ra[0] = ra0; t_ra[1] = ra1;
      t_we = we; t_ad = ad; t_wd = wd; t_ien = ien; t_ird = ird;
      bus.RA       = {AW'(ra1), AW'(ra0)};
      bus.WE3      = we;
      bus.AD3      = AW'(ad);
      bus.WD3      = wd;
      bus.issue_en = ien;
      bus.issue_rd = AW'(ird);
   endtask

   // Compare every output of both instances against the model under the current stimulus.
   task automatic check_outputs();
      logic [DW-1:0] exp_rd;
      bit            exp_rdy, fwd;
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < NR; i++) begin
            fwd = (b == 0) && t_we && t_ad != 0 && t_ad == t_ra[i];
            if (t_ra[i] == 0) begin
               exp_rd = '0; exp_rdy = 1'b1;
            end else if (fwd) begin
               exp_rd = t_wd; exp_rdy = 1'b1;
            end else begin
               exp_rd = mem[t_ra[i]]; exp_rdy = !busy_m[t_ra[i]];
            end
            if (b == 0) begin
               check_eq($sformatf("rd%0d", i), 64'(bus.RD[i*DW +: DW]), 64'(exp_rd));
               check_eq($sformatf("rdy%0d", i), 64'(bus.RDY[i]), 64'(exp_rdy));
            end else begin
               check_eq($sformatf("nb_rd%0d", i), 64'(bus_nb.RD[i*DW +: DW]), 64'(exp_rd));
               check_eq($sformatf("nb_rdy%0d", i), 64'(bus_nb.RDY[i]), 64'(exp_rdy));
            end
         end
      end
      check_eq("waw", 64'(bus.waw_hazard), 64'(t_ien && t_ird != 0 && busy_m[t_ird]));
      check_eq("nb_waw", 64'(bus_nb.waw_hazard), 64'(t_ien && t_ird != 0 && busy_m[t_ird]));
      check_eq("busy_count", 64'(bus.busy_count), 64'(model_count()));
      check_eq("nb_busy_count", 64'(bus_nb.busy_count), 64'(model_count()));
      check_eq("a0", 64'(bus.a0), 64'(mem[10]));
      check_eq("nb_a0", 64'(bus_nb.a0), 64'(mem[10]));
   endtask

   task automatic sample();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic clock();
      @(posedge clk);
      if (!rst) begin
         if (t_we && t_ad != 0) begin
            mem[t_ad]    = t_wd;
            busy_m[t_ad] = 1'b0;
         end
         if (t_ien && t_ird != 0) busy_m[t_ird] = 1'b1;
      end
      #1;
   endtask

   task automatic step();
      sample();
      clock();
   endtask

   initial begin
      model_reset();
      drive(0, 0, 0, 0, '0, 0, 0);
      #1 check_outputs();
      @(negedge clk) rst = 1'b0;
      clock();

      // Async reset mid-cycle wipes a preloaded register and a reservation.
      drive(5, 0, 1, 5, 32'h1234, 1, 9);
      step();
      drive(5, 9, 0, 0, '0, 0, 0);
      sample();
      check_eq("x5_preload", 64'(bus.RD[DW-1:0]), 64'h1234);
      clock();
      #2 rst = 1'b1;
      model_reset();
      #1 check_outputs();
      check_eq("rst_rd_x5", 64'(bus.RD[DW-1:0]), 64'h0);
      check_eq("rst_rdy", 64'(bus.RDY), 64'h3);
      // Write and issue while reset is held across an edge must be dropped.
      drive(0, 0, 1, 6, 32'habc, 1, 6);
      clock();
      drive(6, 0, 0, 0, '0, 0, 0);
      #1 rst = 1'b0;
      step();

      // x0 protection.
      drive(0, 0, 1, 0, 32'hffff_ffff, 0, 0);
      step();
      drive(0, 0, 0, 0, '0, 1, 0);
      step();
      drive(0, 0, 0, 0, '0, 0, 0);
      sample();
      check_eq("x0_count", 64'(bus.busy_count), 64'h0);
      clock();

      // Write x10: bypass before the edge, a0 after it.
      drive(0, 10, 1, 10, 32'hdead_beef, 0, 0);
      sample();
      check_eq("byp_rd1", 64'(bus.RD[DW +: DW]), 64'hdead_beef);
      check_eq("nb_rd1_old", 64'(bus_nb.RD[DW +: DW]), 64'h0);
      clock();
      drive(0, 10, 0, 0, '0, 0, 0);
      sample();
      check_eq("a0_after", 64'(bus.a0), 64'hdead_beef);
      clock();

      // RAW on x7.
      drive(7, 0, 0, 0, '0, 1, 7);
      step();
      drive(7, 0, 0, 0, '0, 0, 0);
      sample();
      check_eq("raw_rdy0", 64'(bus.RDY[0]), 64'h0);
      check_eq("raw_count", 64'(bus.busy_count), 64'h1);
      clock();
      drive(7, 0, 1, 7, 32'h55, 0, 0);
      sample();
      check_eq("raw_wb_rd0", 64'(bus.RD[DW-1:0]), 64'h55);
      check_eq("nb_raw_rdy0", 64'(bus_nb.RDY[0]), 64'h0);
      clock();
      drive(7, 0, 0, 0, '0, 0, 0);
      step();

      // Same-edge issue and writeback on x7: reservation survives, data lands.
      drive(7, 0, 0, 0, '0, 1, 7);
      step();
      drive(7, 0, 1, 7, 32'h77, 1, 7);
      step();
      drive(7, 0, 0, 0, '0, 0, 0);
      sample();
      check_eq("coll_count", 64'(bus.busy_count), 64'h1);
      check_eq("coll_nb_rd0", 64'(bus_nb.RD[DW-1:0]), 64'h77);
      clock();
      drive(0, 0, 1, 7, 32'h78, 0, 0);
      step();

      // WAW on x3.
      drive(3, 4, 0, 0, '0, 1, 3);
      step();
      drive(3, 4, 0, 0, '0, 1, 4);
      step();
      drive(3, 4, 0, 0, '0, 1, 3);
      sample();
      check_eq("waw_third", 64'(bus.waw_hazard), 64'h1);
      clock();
      drive(3, 4, 1, 3, 32'h33, 0, 0);
      sample();
      check_eq("waw_count", 64'(bus.busy_count), 64'h2);
      clock();
      drive(3, 4, 1, 4, 32'h44, 0, 0);
      step();
      drive(3, 4, 0, 0, '0, 0, 0);
      sample();
      check_eq("waw_clear", 64'(bus.busy_count), 64'h0);
      clock();

      // Random traffic; writebacks favour small addresses so reservations get cleared.
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, NREG - 1), $urandom_range(0, 7), ($urandom_range(0, 2) != 0),
               $urandom_range(0, 7) + (($urandom_range(0, 3) == 0) ? 8 * $urandom_range(0, 3) : 0),
               $urandom(), ($urandom_range(0, 2) == 0), $urandom_range(0, 7));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
